// File: rtl/dmem_bridge_pkg.sv
// Shared constants for the data-memory bridge: FSM encodings, bus widths, access decode.
package dmem_bridge_pkg;

   localparam int unsigned DMB_DATA_W = 32;
   localparam int unsigned DMB_BE_W   = 4;
   localparam int unsigned DMB_ST_W   = 2;

   localparam logic [DMB_ST_W-1:0] DMB_IDLE = 2'd0;
   localparam logic [DMB_ST_W-1:0] DMB_BUSY = 2'd1;
   localparam logic [DMB_ST_W-1:0] DMB_DONE = 2'd2;

   // A store with no byte enables is not an access.
   function automatic logic dmb_access(input logic mem_w, input logic mem_r,
                                       input logic [DMB_BE_W-1:0] dwea);
      return (mem_w && (dwea != '0)) || mem_r;
   endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted-write buffer for dmem_bridge; only built with DMEM_WBUF_EN.
`ifdef DMEM_WBUF_EN
module dmem_wbuf
   import dmem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [ADDR_W-1:0]     push_addr,
   input  logic [DMB_BE_W-1:0]   push_be,
   input  logic [DMB_DATA_W-1:0] push_wdata,
   output logic                  valid,
   output logic [ADDR_W-1:0]     addr,
   output logic [DMB_BE_W-1:0]   be,
   output logic [DMB_DATA_W-1:0] wdata
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         addr  <= '0;
         be    <= '0;
         wdata <= '0;
      end else if (push) begin
         valid <= 1'b1;
         addr  <= push_addr;
         be    <= push_be;
         wdata <= push_wdata;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/dmem_bridge.sv
// Converts single-cycle stage memory strobes into a req/ack bus transaction with stall.
// Optional DMEM_WBUF_EN posts stores through a one-entry write buffer.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_w,
   input  logic                  mem_r,
   input  logic [DMB_BE_W-1:0]   DWea,
   input  logic [ADDR_W-1:0]     Addr_out,
   input  logic [DMB_DATA_W-1:0] Data_out,
   output logic [DMB_DATA_W-1:0] Data_in,
   output logic                  stop,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [DMB_BE_W-1:0]   bus_be,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DMB_DATA_W-1:0] bus_wdata,
   input  logic [DMB_DATA_W-1:0] bus_rdata,
   input  logic                  bus_ack
);

   logic [DMB_ST_W-1:0]   state_q, state_d;
   logic [DMB_DATA_W-1:0] rdata_q;
   logic                  access_c, store_c;
   logic                  lat_en, rdata_en;
   logic                  lat_we;
   logic [DMB_BE_W-1:0]   lat_be;
   logic [ADDR_W-1:0]     lat_addr;
   logic [DMB_DATA_W-1:0] lat_wdata;
   logic [ADDR_W-1:0]     stage_addr;

   assign access_c   = dmb_access(mem_w, mem_r, DWea);
   assign store_c    = mem_w && (DWea != '0);
   assign stage_addr = Addr_out & ~ADDR_W'(3);
   assign Data_in    = rdata_q;

`ifdef DMEM_WBUF_EN
   logic                  wb_push, wb_pop, lat_wbuf, wb_valid;
   logic [ADDR_W-1:0]     wb_addr;
   logic [DMB_BE_W-1:0]   wb_be;
   logic [DMB_DATA_W-1:0] wb_wdata;

   dmem_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
      .clk        (clk),
      .rst        (rst),
      .push       (wb_push),
      .pop        (wb_pop),
      .push_addr  (stage_addr),
      .push_be    (DWea),
      .push_wdata (Data_out),
      .valid      (wb_valid),
      .addr       (wb_addr),
      .be         (wb_be),
      .wdata      (wb_wdata)
   );

   // A drain takes its fields from the buffer; everything else from the stage.
   always_comb begin
      if (lat_wbuf) begin
         lat_we    = 1'b1;
         lat_be    = wb_be;
         lat_addr  = wb_addr;
         lat_wdata = wb_wdata;
      end else begin
         lat_we    = store_c;
         lat_be    = store_c ? DWea : '1;
         lat_addr  = stage_addr;
         lat_wdata = Data_out;
      end
   end
`else
   always_comb begin
      lat_we    = store_c;
      lat_be    = store_c ? DWea : '1;
      lat_addr  = stage_addr;
      lat_wdata = Data_out;
   end
`endif

   // Next state, stall and register enables; stop never looks at bus_ack.
   always_comb begin
      state_d  = state_q;
      stop     = 1'b0;
      lat_en   = 1'b0;
      rdata_en = 1'b0;
`ifdef DMEM_WBUF_EN
      wb_push  = 1'b0;
      wb_pop   = 1'b0;
      lat_wbuf = 1'b0;
`endif
      case (state_q)
         DMB_IDLE: begin
`ifdef DMEM_WBUF_EN
            if (wb_valid) begin
               stop     = access_c;
               lat_en   = 1'b1;
               lat_wbuf = 1'b1;
               state_d  = DMB_BUSY;
            end else if (store_c) begin
               wb_push = 1'b1;
            end else if (mem_r) begin
               stop    = 1'b1;
               lat_en  = 1'b1;
               state_d = DMB_BUSY;
            end
`else
            if (access_c) begin
               stop    = 1'b1;
               lat_en  = 1'b1;
               state_d = DMB_BUSY;
            end
`endif
         end
         DMB_BUSY: begin
`ifdef DMEM_WBUF_EN
            // Only buffer drains are writes here; they stall just a waiting access.
            stop = bus_we ? access_c : 1'b1;
            if (bus_ack) begin
               if (bus_we) begin
                  wb_pop  = 1'b1;
                  state_d = DMB_IDLE;
               end else begin
                  rdata_en = 1'b1;
                  state_d  = DMB_DONE;
               end
            end
`else
            stop = 1'b1;
            if (bus_ack) begin
               rdata_en = !bus_we;
               state_d  = DMB_DONE;
            end
`endif
         end
         DMB_DONE: state_d = DMB_IDLE;
         default:  state_d = DMB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DMB_IDLE;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_be    <= '0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         bus_req <= (state_d == DMB_BUSY);
         if (lat_en) begin
            bus_we    <= lat_we;
            bus_be    <= lat_be;
            bus_addr  <= lat_addr;
            bus_wdata <= lat_wdata;
         end
         if (rdata_en) rdata_q <= bus_rdata;
      end
   end

endmodule
